// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the decode-stage branch controller.
// Forwarding sources, branch-op encodings, FSM states and the target adder.
package branch_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

    typedef enum logic {
        BR_BEQ = 1'b0,
        BR_BNE = 1'b1
    } br_op_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_e;

    // Offset is a word count: sign-extend, scale by 4, wrap at 32 bits.
    function automatic logic [31:0] br_target_calc(
        input logic [31:0] pc,
        input logic [15:0] imm
    );
        return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode-side bundle between the pipeline and the branch controller.
// master is the pipeline side, slave is the controller.
interface branch_ctrl_if #(
    parameter int CNT_W = 16
);

    logic             D_is_br;
    logic             D_br_op;
    logic [4:0]       D_rs;
    logic [4:0]       D_rt;
    logic [31:0]      D_pc;
    logic [15:0]      D_imm16;
    logic             E_we;
    logic             M_we;
    logic             W_we;
    logic [4:0]       E_wa;
    logic [4:0]       M_wa;
    logic [4:0]       W_wa;
    logic             M_is_load;
    logic             cmp_eq;
    logic             stall;
    logic [1:0]       fwd_rs;
    logic [1:0]       fwd_rt;
    logic             br_taken;
    logic             npc_sel;
    logic [31:0]      br_target;
    logic [CNT_W-1:0] n_br;
    logic [CNT_W-1:0] n_taken;
    logic [CNT_W-1:0] n_stall;
    logic             err;

    modport master (
        output D_is_br, D_br_op, D_rs, D_rt, D_pc, D_imm16,
        output E_we, M_we, W_we, E_wa, M_wa, W_wa,
        output M_is_load, cmp_eq,
        input  stall, fwd_rs, fwd_rt, br_taken, npc_sel,
        input  br_target, n_br, n_taken, n_stall, err
    );

    modport slave (
        input  D_is_br, D_br_op, D_rs, D_rt, D_pc, D_imm16,
        input  E_we, M_we, W_we, E_wa, M_wa, W_wa,
        input  M_is_load, cmp_eq,
        output stall, fwd_rs, fwd_rt, br_taken, npc_sel,
        output br_target, n_br, n_taken, n_stall, err
    );

endinterface

// File: rtl/branch_ctrl_hazard_unit.sv
// Per-source hazard check for one branch operand.
// E result never reaches decode; an M load is not ready either.
module hazard_unit
    import branch_ctrl_pkg::*;
(
    input  logic       en,
    input  logic [4:0] src,
    input  logic       e_we,
    input  logic [4:0] e_wa,
    input  logic       m_we,
    input  logic [4:0] m_wa,
    input  logic       m_is_load,
    input  logic       w_we,
    input  logic [4:0] w_wa,
    output logic       stall,
    output logic [1:0] fwd
);

    always_comb begin
        stall = 1'b0;
        fwd   = FWD_RF;
        if (en && src != 5'd0) begin
            if (e_we && e_wa == src) begin
                stall = 1'b1;
            end else if (m_we && m_wa == src) begin
                if (m_is_load) stall = 1'b1;
                else           fwd   = FWD_M;
            end else if (w_we && w_wa == src) begin
                fwd = FWD_W;
            end
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Decode-stage branch resolution: hazard stall, forwarding selects,
// taken decision, target, saturating statistics and stall-timeout flag.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 2
) (
    input  logic          clk,
    input  logic          reset,
    branch_ctrl_if.slave  bus
);

    localparam int SW = ($clog2(MAX_STALL + 2) < 2) ? 2 : $clog2(MAX_STALL + 2);
    localparam logic [SW-1:0] SCNT_LIM = SW'(MAX_STALL);
    localparam logic [SW-1:0] SCNT_TOP = SW'(MAX_STALL + 1);

    logic             st_rs;
    logic             st_rt;
    logic             hz;
    logic             stall;
    logic             resolve;
    logic             taken;
    state_e           state;
    state_e           state_nx;
    logic [SW-1:0]    scnt;
    logic             err;
    logic [CNT_W-1:0] n_br;
    logic [CNT_W-1:0] n_taken;
    logic [CNT_W-1:0] n_stall;

    hazard_unit u_hz_rs (
        .en        (bus.D_is_br),
        .src       (bus.D_rs),
        .e_we      (bus.E_we),
        .e_wa      (bus.E_wa),
        .m_we      (bus.M_we),
        .m_wa      (bus.M_wa),
        .m_is_load (bus.M_is_load),
        .w_we      (bus.W_we),
        .w_wa      (bus.W_wa),
        .stall     (st_rs),
        .fwd       (bus.fwd_rs)
    );

    hazard_unit u_hz_rt (
        .en        (bus.D_is_br),
        .src       (bus.D_rt),
        .e_we      (bus.E_we),
        .e_wa      (bus.E_wa),
        .m_we      (bus.M_we),
        .m_wa      (bus.M_wa),
        .m_is_load (bus.M_is_load),
        .w_we      (bus.W_we),
        .w_wa      (bus.W_wa),
        .stall     (st_rt),
        .fwd       (bus.fwd_rt)
    );

    assign hz      = st_rs | st_rt;
    assign stall   = hz & ~reset;
    assign resolve = bus.D_is_br & ~hz & ~reset;
    assign taken   = resolve &
                     ((bus.D_br_op == BR_BNE) ? ~bus.cmp_eq : bus.cmp_eq);

    assign bus.stall     = stall;
    assign bus.br_taken  = taken;
    assign bus.npc_sel   = taken;
    assign bus.br_target = br_target_calc(bus.D_pc, bus.D_imm16);
    assign bus.n_br      = n_br;
    assign bus.n_taken   = n_taken;
    assign bus.n_stall   = n_stall;
    assign bus.err       = err;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (stall)  state_nx = S_STALL;
            S_STALL: if (!stall) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // scnt counts consecutive stalled cycles of the branch held in decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            scnt  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx == S_IDLE) begin
                scnt <= '0;
            end else begin
                if (scnt != SCNT_TOP) scnt <= scnt + SW'(1);
                if (scnt >= SCNT_LIM) err  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_br    <= '0;
            n_taken <= '0;
            n_stall <= '0;
        end else begin
            if (resolve && n_br != '1)    n_br    <= n_br + CNT_W'(1);
            if (taken && n_taken != '1)   n_taken <= n_taken + CNT_W'(1);
            if (stall && n_stall != '1)   n_stall <= n_stall + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed and random stimulus for branch_ctrl against a behavioural model.
// Two instances share stimulus: default sizing and a tiny-counter, MAX_STALL=1 one.
module tb_branch_ctrl;
    import branch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_ctrl_if #(.CNT_W(16)) bus0 ();
    branch_ctrl_if #(.CNT_W(2))  bus1 ();

    assign bus1.D_is_br   = bus0.D_is_br;
    assign bus1.D_br_op   = bus0.D_br_op;
    assign bus1.D_rs      = bus0.D_rs;
    assign bus1.D_rt      = bus0.D_rt;
    assign bus1.D_pc      = bus0.D_pc;
    assign bus1.D_imm16   = bus0.D_imm16;
    assign bus1.E_we      = bus0.E_we;
    assign bus1.M_we      = bus0.M_we;
    assign bus1.W_we      = bus0.W_we;
    assign bus1.E_wa      = bus0.E_wa;
    assign bus1.M_wa      = bus0.M_wa;
    assign bus1.W_wa      = bus0.W_wa;
    assign bus1.M_is_load = bus0.M_is_load;
    assign bus1.cmp_eq    = bus0.cmp_eq;

    branch_ctrl #(.CNT_W(16), .MAX_STALL(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    branch_ctrl #(.CNT_W(2), .MAX_STALL(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    int m_nbr  [2];
    int m_ntk  [2];
    int m_nst  [2];
    int m_run  [2];
    bit m_err  [2];
    int cap    [2] = '{65535, 3};
    int mxs    [2] = '{2, 1};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_nbr[i] = 0;
            m_ntk[i] = 0;
            m_nst[i] = 0;
            m_run[i] = 0;
            m_err[i] = 1'b0;
        end
    endtask

    // Youngest in-flight writer of src decides: E or M-load -> wait, M -> 1, W -> 2.
    task automatic ref_src(input logic [4:0] s, output bit st,
                           output logic [1:0] f);
        st = 1'b0;
        f  = 2'd0;
        if (bus0.D_is_br && s != 5'd0) begin
            if (bus0.E_we && bus0.E_wa == s) st = 1'b1;
            else if (bus0.M_we && bus0.M_wa == s) begin
                if (bus0.M_is_load) st = 1'b1;
                else f = 2'd1;
            end else if (bus0.W_we && bus0.W_wa == s) f = 2'd2;
        end
    endtask

    task automatic drive(input bit br, input bit op, input int rs,
                         input int rt, input logic [31:0] pc,
                         input logic [15:0] imm, input bit ew,
                         input int ea, input bit mw, input int ma,
                         input bit ml, input bit ww, input int wa,
                         input bit eq);
        bus0.D_is_br   = br;
        bus0.D_br_op   = op;
        bus0.D_rs      = 5'(rs);
        bus0.D_rt      = 5'(rt);
        bus0.D_pc      = pc;
        bus0.D_imm16   = imm;
        bus0.E_we      = ew;
        bus0.E_wa      = 5'(ea);
        bus0.M_we      = mw;
        bus0.M_wa      = 5'(ma);
        bus0.M_is_load = ml;
        bus0.W_we      = ww;
        bus0.W_wa      = 5'(wa);
        bus0.cmp_eq    = eq;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ":n_br0"},    bus0.n_br,    m_nbr[0]);
        chk({tag, ":n_taken0"}, bus0.n_taken, m_ntk[0]);
        chk({tag, ":n_stall0"}, bus0.n_stall, m_nst[0]);
        chk({tag, ":err0"},     bus0.err,     m_err[0]);
        chk({tag, ":n_br1"},    bus1.n_br,    m_nbr[1]);
        chk({tag, ":n_taken1"}, bus1.n_taken, m_ntk[1]);
        chk({tag, ":n_stall1"}, bus1.n_stall, m_nst[1]);
        chk({tag, ":err1"},     bus1.err,     m_err[1]);
    endtask

    // Called #1 after a rising edge with inputs set; ends #1 after the next edge.
    task automatic step(input string tag);
        bit          sr, st, hz, res, tk;
        logic [1:0]  fr, ft;
        logic [31:0] tgt;
        #3;
        ref_src(bus0.D_rs, sr, fr);
        ref_src(bus0.D_rt, st, ft);
        hz  = sr | st;
        res = bus0.D_is_br && !hz;
        tk  = res && (bus0.cmp_eq != bus0.D_br_op);
        tgt = bus0.D_pc + 32'd4 + ({{16{bus0.D_imm16[15]}}, bus0.D_imm16} << 2);
        chk({tag, ":stall"},    bus0.stall,     hz);
        chk({tag, ":fwd_rs"},   bus0.fwd_rs,    fr);
        chk({tag, ":fwd_rt"},   bus0.fwd_rt,    ft);
        chk({tag, ":br_taken"}, bus0.br_taken,  tk);
        chk({tag, ":npc_sel"},  bus0.npc_sel,   tk);
        chk({tag, ":target"},   bus0.br_target, tgt);
        chk({tag, ":stall1"},   bus1.stall,     hz);
        chk({tag, ":taken1"},   bus1.br_taken,  tk);
        for (int i = 0; i < 2; i++) begin
            if (hz) begin
                if (m_nst[i] < cap[i]) m_nst[i]++;
                m_run[i]++;
                if (m_run[i] > mxs[i]) m_err[i] = 1'b1;
            end else begin
                m_run[i] = 0;
            end
            if (res && m_nbr[i] < cap[i]) m_nbr[i]++;
            if (tk && m_ntk[i] < cap[i])  m_ntk[i]++;
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    initial begin
        reset = 1'b1;
        model_clear();
        drive(1, 0, 5, 0, 32'h0, 16'h0, 1, 5, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst:stall", bus0.stall, 1'b0);
        chk("rst:taken", bus0.br_taken, 1'b0);
        chk("rst:npc", bus0.npc_sel, 1'b0);
        chk("rst:state", dut0.state, S_IDLE);
        check_regs("rst");
        drive(0, 0, 0, 0, 32'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        drive(1, 0, 0, 0, 32'h3000, 16'h0004, 0, 0, 0, 0, 0, 0, 0, 1);
        step("beq0");
        chk("beq0:tgt", bus0.br_target, 32'h0000_3014);
        chk("beq0:nbr", bus0.n_br, 16'd1);

        drive(1, 1, 5, 0, 32'h100, 16'h0010, 1, 5, 0, 0, 0, 0, 0, 0);
        step("alu_e");
        drive(1, 1, 5, 0, 32'h100, 16'h0010, 0, 0, 1, 5, 0, 0, 0, 0);
        step("alu_m");
        chk("alu:nstall", bus0.n_stall, 16'd1);

        drive(1, 0, 0, 8, 32'h200, 16'hfffc, 1, 8, 0, 0, 0, 0, 0, 1);
        step("ld_e");
        drive(1, 0, 0, 8, 32'h200, 16'hfffc, 0, 0, 1, 8, 1, 0, 0, 1);
        step("ld_m");
        drive(1, 0, 0, 8, 32'h200, 16'hfffc, 0, 0, 0, 0, 0, 1, 8, 1);
        step("ld_w");
        chk("ld:err0", bus0.err, 1'b0);
        chk("ld:err1", bus1.err, 1'b1);

        drive(1, 0, 0, 0, 32'h40, 16'h0, 1, 0, 1, 0, 1, 0, 0, 0);
        step("r0");
        drive(1, 1, 3, 3, 32'h40, 16'h0, 1, 3, 1, 3, 0, 0, 0, 0);
        step("em3");
        drive(0, 1, 3, 3, 32'h40, 16'h0, 1, 3, 1, 3, 0, 0, 0, 0);
        step("nobr");

        drive(1, 0, 0, 0, 32'h0000_0010, 16'h8000, 0, 0, 0, 0, 0, 0, 0, 0);
        step("negimm");
        chk("negimm:tgt", bus0.br_target, 32'hFFFE_0014);
        for (int k = 0; k < 3; k++) step("sat");
        chk("sat:nbr1", bus1.n_br, 2'b11);

        drive(1, 0, 0, 9, 32'h300, 16'h1, 1, 9, 0, 0, 0, 0, 0, 1);
        step("rs_e");
        drive(1, 0, 0, 9, 32'h300, 16'h1, 0, 0, 1, 9, 1, 0, 0, 1);
        #3;
        reset = 1'b1;
        model_clear();
        #1;
        chk("mid:stall0", bus0.stall, 1'b0);
        chk("mid:stall1", bus1.stall, 1'b0);
        check_regs("mid");
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid:state", dut0.state, S_IDLE);
        drive(1, 0, 7, 0, 32'h500, 16'h2, 0, 0, 1, 7, 1, 0, 0, 1);
        step("post1");
        drive(1, 0, 7, 0, 32'h500, 16'h2, 0, 0, 0, 0, 0, 1, 7, 1);
        step("post2");

        for (int n = 0; n < 300; n++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom()),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom(), 16'($urandom()),
                  1'($urandom()), $urandom_range(0, 7),
                  1'($urandom()), $urandom_range(0, 7), 1'($urandom()),
                  1'($urandom()), $urandom_range(0, 7), 1'($urandom()));
            step("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution controller for the decode stage of the five-stage pipelined CPU. It sequences the decode-stage equality comparator: it decides when both compare operands are valid, selects their forwarding sources, stalls decode on unresolved hazards, and produces the taken decision, target and next-PC select once the comparison is valid. It also keeps saturating branch statistics and a sticky stall-timeout error flag.

## Interface
Parameters:
- CNT_W, 16, width of each statistics counter
- MAX_STALL, 2, longest legal consecutive stall for one branch; exceeding it sets err

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- D_is_br  in  1  decode holds a conditional branch
- D_br_op  in  1  0 = beq, 1 = bne
- D_rs, D_rt  in  5 each  branch source registers
- D_pc  in  32  PC of the branch
- D_imm16  in  16  branch offset
- E_we, M_we, W_we  in  1 each  stage will write the register file
- E_wa, M_wa, W_wa  in  5 each  stage destination register
- M_is_load  in  1  memory-stage instruction is a load
- cmp_eq  in  1  comparator output, equality of the forwarded operands
- stall  out  1  freeze PC and F/D register, bubble into E
- fwd_rs, fwd_rt  out  2 each  0 = register file, 1 = M result, 2 = W result
- br_taken  out  1  branch resolved and taken this cycle
- npc_sel  out  1  1 = PC loads br_target
- br_target  out  32  D_pc + 4 + (sign-extended D_imm16 << 2)
- n_br, n_taken, n_stall  out  CNT_W each  statistics counters
- err  out  1  sticky stall-timeout flag

## Operation
- Hazard per source s (rs, rt), only when D_is_br=1 and s≠0:
  - E_we and E_wa=s: stall (E result is not available in decode).
  - Otherwise M_we and M_wa=s and M_is_load: stall.
  - Otherwise M_we and M_wa=s: fwd=1.
  - Otherwise W_we and W_wa=s: fwd=2.
  - Otherwise fwd=0.
  - Priority is E > M > W. stall is the OR over rs and rt.
- fwd_* is 0 whenever D_is_br=0 or the source register is 0.
- Resolution: when D_is_br=1 and stall=0, the branch resolves. br_taken = cmp_eq XOR D_br_op, and npc_sel = br_taken. Otherwise br_taken = npc_sel = 0.
- br_target is combinational at all times: 32-bit wrap-around add with the carry discarded.
- Delay slot is architectural. The controller never flushes.
- FSM states:
  - IDLE: go to STALL if D_is_br and stall; else stay in IDLE.
  - STALL: stay in STALL while D_is_br and stall; go to IDLE on resolution or when D_is_br drops.
- Stall counter: scnt (2 bits minimum) increments each STALL cycle and clears on entering IDLE. err is set when scnt would exceed MAX_STALL, and stays set until reset.
- Statistics, all saturating at all-ones and never wrapping:
  - n_br increments once per resolution.
  - n_taken increments on resolution with br_taken=1.
  - n_stall increments each cycle stall=1.

## Timing
- stall, fwd_*, br_taken, npc_sel and br_target are combinational from the current inputs. Decision latency is 0 cycles after operands become available.
- FSM, scnt, counters and err update on the rising edge of clk.
- Reset state: state=IDLE, scnt=0, n_br=n_taken=n_stall=0, err=0. While reset=1, stall, br_taken and npc_sel are forced to 0.
- Reset asserted mid-stall returns to IDLE immediately. It does not set err and does not count a branch.
- Load in E feeding the branch: 2 stall cycles (the load is in E, then in M), then resolve with fwd=2.
- ALU op in E feeding the branch: 1 stall cycle, then resolve with fwd=1.
- rs hazard and rt hazard in the same cycle: one stall; counters increment once per cycle.
- A counter at saturation holds its value.

## Structure
- Shared package: fwd-source constants (FWD_RF=0, FWD_M=1, FWD_W=2), branch-op encodings (BR_BEQ, BR_BNE) and FSM state encoding.
- One sub-module: hazard_unit. It is purely combinational, computes the per-source stall and fwd, and is instantiated twice (rs, rt).
- FSM, counters and target adder stay in branch_ctrl. The comparator stays a separate instance in decode.

## Test plan
- beq, rs=rt=0, cmp_eq=1, D_pc=0x3000, imm=0x0004: stall=0, br_taken=1, npc_sel=1, br_target=0x3014, n_br=1 next edge.
- bne, rs=$5 with ALU op in E writing $5: stall=1 for 1 cycle, then fwd_rs=1, cmp_eq=0 → br_taken=1; n_stall=1.
- beq, rt=$8 with lw $8 in E: stall for 2 cycles, then fwd_rt=2; err stays 0. With MAX_STALL=1, err=1 and stays 1.
- E writes $0 and M load writes $0, branch uses $0: no stall, fwd=0. E and M both write $3: E wins, stall=1.
- imm=0x8000, D_pc=0x0000_0010: br_target=0xFFFE_0014. n_br preloaded near all-ones plus 3 resolutions: n_br holds all-ones.
- Assert reset during the second stall cycle: stall→0 immediately, counters and err cleared, FSM in IDLE after release.
